// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter: FSM encoding and requester-id sizing.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    // An id field needs at least one bit even when there are only two requesters.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request scanning upward from last_grant+1 with wrap.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int NUM_REQ  = 4,
    localparam int ID_WIDTH = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] last_grant,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] grant_idx,
    output logic                grant_any
);

    logic [ID_WIDTH-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = '0;
        // off = NUM_REQ lands back on last_grant, so it is considered last
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = ID_WIDTH'((int'(last_grant) + off) % NUM_REQ);
            if (!grant_any && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                grant_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one single-port synchronous memory among NUM_REQ requesters,
// one transaction at a time through an issue / read-wait / response sequence.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int ADDR_WIDTH = 16,
    parameter  int DEPTH      = 1024,
    parameter  int NUM_REQ    = 4,
    localparam int ID_WIDTH   = id_width(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic                           rsp_valid,
    output logic [ID_WIDTH-1:0]            rsp_id,
    output logic [DATA_WIDTH-1:0]          rsp_data,
    output logic                           rsp_err,
    output logic                           mem_en,
    output logic                           mem_we,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    output logic [DATA_WIDTH-1:0]          mem_wdata,
    input  logic [DATA_WIDTH-1:0]          mem_rdata,
    output logic                           busy
);

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [ID_WIDTH-1:0]   id;
        logic                  err;
    } cap_req_t;

    // One extra bit so DEPTH == 2**ADDR_WIDTH still compares correctly
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(DEPTH);

    arb_state_e            state_q, state_d;
    cap_req_t              cap_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [ID_WIDTH-1:0]   last_grant_q;

    logic [NUM_REQ-1:0]                 grant;
    logic [ID_WIDTH-1:0]                grant_idx;
    logic                               grant_any;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_arr;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wdata_arr;
    logic [ADDR_WIDTH-1:0]              sel_addr;
    logic [DATA_WIDTH-1:0]              sel_wdata;
    logic                               sel_oob;
    logic                               accept;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_any  (grant_any)
    );

    assign addr_arr  = req_addr;
    assign wdata_arr = req_wdata;
    assign sel_addr  = addr_arr[grant_idx];
    assign sel_wdata = wdata_arr[grant_idx];
    assign sel_oob   = {1'b0, sel_addr} >= ADDR_LIMIT;
    assign accept    = (state_q == IDLE) && grant_any;
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        rsp_valid = 1'b0;
        rsp_id    = '0;
        rsp_data  = '0;
        rsp_err   = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = grant;
                if (grant_any) state_d = sel_oob ? RESP : ISSUE;
            end
            ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = cap_q.we;
                mem_addr  = cap_q.addr;
                mem_wdata = cap_q.wdata;
                state_d   = cap_q.we ? RESP : WAIT;
            end
            WAIT: state_d = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                rsp_id    = cap_q.id;
                rsp_data  = rdata_q;
                rsp_err   = cap_q.err;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // rdata_q is cleared on accept so writes and trapped requests respond with zero data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cap_q        <= '0;
            rdata_q      <= '0;
            last_grant_q <= ID_WIDTH'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            if (accept) begin
                cap_q        <= '{we: req_we[grant_idx], addr: sel_addr, wdata: sel_wdata,
                                  id: grant_idx, err: sel_oob};
                rdata_q      <= '0;
                last_grant_q <= grant_idx;
            end else if (state_q == WAIT) begin
                rdata_q <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus a randomized run scored against a transaction-level model
// (round-robin winner, fixed per-kind latency, array memory).
module tb_mem_port_arbiter;
    localparam int DW = 8, AW = 16, DEPTH = 1024, NR = 4, IW = 2;

    logic clk = 1'b0;
    logic reset;
    logic [NR-1:0]    req_valid, req_ready, req_we;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic             rsp_valid, rsp_err, mem_en, mem_we, busy;
    logic [IW-1:0]    rsp_id;
    logic [DW-1:0]    rsp_data, mem_wdata;
    logic [DW-1:0]    mem_rdata = '0;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem [DEPTH];
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .NUM_REQ(NR)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[9:0]];
        end
    end

    task automatic set_req(input int i, input bit v, input bit we, input int a, input int d);
        req_valid[i]           = v;
        req_we[i]              = we;
        req_addr[i*AW +: AW]   = AW'(a);
        req_wdata[i*DW +: DW]  = DW'(d);
    endtask

    task automatic clr_all();
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clr_all();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, mem_en, mem_we, mem_addr, mem_wdata, busy} !== '0) begin
            errors++;
            $display("FAIL reset_held: got rdy=%b rv=%b en=%b busy=%b want all 0", req_ready, rsp_valid, mem_en, busy);
        end
        @(negedge clk) reset = 1'b1;
        step();
        checks++;
        if ({req_ready, rsp_valid, mem_en, busy} !== '0) begin
            errors++;
            $display("FAIL reset_release: got rdy=%b rv=%b en=%b busy=%b want 0", req_ready, rsp_valid, mem_en, busy);
        end
    endtask

    task automatic test_write();
        step(); set_req(2, 1, 1, 5, 'hA5); #1;
        checks++;
        if (req_ready !== 4'b0100) begin errors++; $display("FAIL wr_ready: got %b want 0100", req_ready); end
        step(); set_req(2, 0, 0, 0, 0); #1;
        checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata, busy} !== {1'b1, 1'b1, 16'd5, 8'hA5, 1'b1}) begin
            errors++;
            $display("FAIL wr_issue: got en=%b we=%b addr=%0d wd=%h busy=%b want 1 1 5 a5 1", mem_en, mem_we, mem_addr, mem_wdata, busy);
        end
        step();
        checks++;
        if ({rsp_valid, rsp_id, rsp_err, rsp_data, mem_en} !== {1'b1, 2'd2, 1'b0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL wr_resp: got v=%b id=%0d err=%b d=%h en=%b want 1 2 0 00 0", rsp_valid, rsp_id, rsp_err, rsp_data, mem_en);
        end
        step();
        checks++;
        if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL wr_idle: got v=%b busy=%b want 0 0", rsp_valid, busy); end
    endtask

    task automatic test_read();
        step(); set_req(1, 1, 0, 5, 0); #1;
        checks++;
        if (req_ready !== 4'b0010) begin errors++; $display("FAIL rd_ready: got %b want 0010", req_ready); end
        step(); set_req(1, 0, 0, 0, 0); #1;
        checks++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 16'd5}) begin
            errors++;
            $display("FAIL rd_issue: got en=%b we=%b addr=%0d want 1 0 5", mem_en, mem_we, mem_addr);
        end
        step();
        checks++;
        if ({rsp_valid, mem_en, busy} !== 3'b001) begin
            errors++;
            $display("FAIL rd_wait: got v=%b en=%b busy=%b want 0 0 1", rsp_valid, mem_en, busy);
        end
        step();
        checks++;
        if ({rsp_valid, rsp_id, rsp_err, rsp_data} !== {1'b1, 2'd1, 1'b0, 8'hA5}) begin
            errors++;
            $display("FAIL rd_resp: got v=%b id=%0d err=%b d=%h want 1 1 0 a5", rsp_valid, rsp_id, rsp_err, rsp_data);
        end
        step();
    endtask

    task automatic test_oob();
        for (int k = 0; k < 2; k++) begin
            int a;
            a = (k == 0) ? DEPTH : DEPTH - 1;
            step(); set_req(3, 1, 0, a, 0); #1;
            checks++;
            if (req_ready !== 4'b1000) begin errors++; $display("FAIL oob_ready addr=%0d: got %b want 1000", a, req_ready); end
            step(); set_req(3, 0, 0, 0, 0); #1;
            if (k == 0) begin
                checks++;
                if ({rsp_valid, rsp_id, rsp_err, rsp_data, mem_en} !== {1'b1, 2'd3, 1'b1, 8'h00, 1'b0}) begin
                    errors++;
                    $display("FAIL oob_trap: got v=%b id=%0d err=%b d=%h en=%b want 1 3 1 00 0", rsp_valid, rsp_id, rsp_err, rsp_data, mem_en);
                end
            end else begin
                checks++;
                if ({mem_en, mem_we, mem_addr, rsp_valid} !== {1'b1, 1'b0, 16'd1023, 1'b0}) begin
                    errors++;
                    $display("FAIL edge_issue: got en=%b we=%b addr=%0d v=%b want 1 0 1023 0", mem_en, mem_we, mem_addr, rsp_valid);
                end
                step(); step();
                checks++;
                if ({rsp_valid, rsp_id, rsp_err, rsp_data} !== {1'b1, 2'd3, 1'b0, 8'h00}) begin
                    errors++;
                    $display("FAIL edge_resp: got v=%b id=%0d err=%b d=%h want 1 3 0 00", rsp_valid, rsp_id, rsp_err, rsp_data);
                end
            end
            step();
        end
    endtask

    task automatic test_round_robin();
        int order[$];
        int exp_order[5] = '{0, 1, 2, 3, 0};
        logic [NR-1:0] prev;
        prev = '0;
        step();
        for (int i = 0; i < NR; i++) set_req(i, 1, 1, 300 + i, 16 * i);
        #1;
        for (int c = 0; c < 40 && order.size() < 5; c++) begin
            if (req_ready !== '0) begin
                checks++;
                if ($countones(req_ready) != 1 || prev !== '0) begin
                    errors++;
                    $display("FAIL rr_onehot: got %b (prev %b) want single-cycle one-hot", req_ready, prev);
                end
                for (int i = 0; i < NR; i++) if (req_ready[i]) order.push_back(i);
            end
            prev = req_ready;
            @(posedge clk); #2;
        end
        clr_all();
        checks++;
        if (order.size() != 5) begin
            errors++;
            $display("FAIL rr_count: got %0d grants want 5", order.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (order[k] != exp_order[k]) begin
                    errors++;
                    $display("FAIL rr_order[%0d]: got %0d want %0d", k, order[k], exp_order[k]);
                end
            end
        end
        repeat (5) step();
    endtask

    task automatic test_rerequest();
        logic [NR-1:0] got;
        step(); set_req(0, 1, 1, 400, 1); #1;
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL rq_first: got %b want 0001", req_ready); end
        step(); set_req(0, 0, 0, 0, 0); set_req(3, 1, 1, 401, 2); #1;
        step();
        checks++;
        if ({rsp_valid, rsp_id} !== {1'b1, 2'd0}) begin
            errors++;
            $display("FAIL rq_resp0: got v=%b id=%0d want 1 0", rsp_valid, rsp_id);
        end
        step(); set_req(0, 1, 1, 402, 3); #1;
        checks++;
        if (req_ready !== 4'b1000) begin errors++; $display("FAIL rq_pending_wins: got %b want 1000", req_ready); end
        step(); set_req(3, 0, 0, 0, 0); #1;
        got = req_ready;
        for (int c = 0; c < 10 && got == '0; c++) begin
            step();
            got = req_ready;
        end
        checks++;
        if (got !== 4'b0001) begin errors++; $display("FAIL rq_second: got %b want 0001", got); end
        step();
        clr_all();
        repeat (4) step();
    endtask

    task automatic test_reset_mid_wait();
        bit seen;
        seen = 0;
        step(); set_req(1, 1, 0, 5, 0); #1;
        step(); set_req(1, 0, 0, 0, 0); #1;
        step();
        checks++;
        if ({busy, mem_en, rsp_valid} !== 3'b100) begin
            errors++;
            $display("FAIL rst_in_wait: got busy=%b en=%b v=%b want 1 0 0", busy, mem_en, rsp_valid);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({busy, rsp_valid} !== 2'b00) begin
            errors++;
            $display("FAIL rst_async: got busy=%b v=%b want 0 0", busy, rsp_valid);
        end
        repeat (3) begin step(); if (rsp_valid !== 1'b0) seen = 1; end
        @(negedge clk) reset = 1'b1;
        repeat (4) begin step(); if (rsp_valid !== 1'b0 || busy !== 1'b0) seen = 1; end
        checks++;
        if (seen) begin errors++; $display("FAIL rst_no_resp: got a response or busy after reset, want none"); end
    endtask

    task automatic test_random();
        bit pend[NR];
        bit pwe[NR];
        int paddr[NR], pdata[NR];
        int ref_mem[DEPTH];
        int last = NR - 1;
        int acc = -100, free = 0, issue = -1, rspc = -1;
        logic [IW-1:0] e_id;
        logic [DW-1:0] e_data, e_wdata;
        logic          e_err, e_we;
        logic [AW-1:0] e_addr;
        logic [NR-1:0] exp_ready;
        int w;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 0;
        for (int i = 0; i < NR; i++) pend[i] = 0;
        e_id = '0; e_data = '0; e_wdata = '0; e_err = 0; e_we = 0; e_addr = '0;
        clr_all();
        for (int cyc = 0; cyc < 600; cyc++) begin
            step();
            for (int i = 0; i < NR; i++) begin
                if (!pend[i]) begin
                    set_req(i, 0, 0, 0, 0);
                    if ($urandom_range(0, 2) == 0) begin
                        pend[i]  = 1;
                        pwe[i]   = 1'($urandom_range(0, 1));
                        paddr[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(DEPTH - 3, DEPTH + 3))
                                                              : 200 + int'($urandom_range(0, 15));
                        pdata[i] = int'($urandom_range(0, 255));
                        set_req(i, 1, pwe[i], paddr[i], pdata[i]);
                    end
                end
            end
            #1;
            w = -1;
            exp_ready = '0;
            if (cyc >= free)
                for (int k = 1; k <= NR; k++) begin
                    int idx;
                    idx = (last + k) % NR;
                    if (w < 0 && pend[idx]) w = idx;
                end
            if (w >= 0) exp_ready[w] = 1'b1;
            checks++;
            if (req_ready !== exp_ready) begin
                errors++; $display("FAIL rnd_ready c%0d: got %b want %b", cyc, req_ready, exp_ready);
            end
            checks++;
            if (rsp_valid !== (cyc == rspc)) begin
                errors++; $display("FAIL rnd_rsp_valid c%0d: got %b want %b", cyc, rsp_valid, cyc == rspc);
            end
            if (cyc == rspc) begin
                checks++;
                if ({rsp_id, rsp_data, rsp_err} !== {e_id, e_data, e_err}) begin
                    errors++;
                    $display("FAIL rnd_rsp c%0d: got id=%0d d=%h err=%b want id=%0d d=%h err=%b", cyc, rsp_id, rsp_data, rsp_err, e_id, e_data, e_err);
                end
            end
            checks++;
            if (mem_en !== (cyc == issue)) begin
                errors++; $display("FAIL rnd_mem_en c%0d: got %b want %b", cyc, mem_en, cyc == issue);
            end
            if (cyc == issue) begin
                checks++;
                if ({mem_we, mem_addr, mem_wdata} !== {e_we, e_addr, e_wdata}) begin
                    errors++;
                    $display("FAIL rnd_mem c%0d: got we=%b a=%0d wd=%h want we=%b a=%0d wd=%h", cyc, mem_we, mem_addr, mem_wdata, e_we, e_addr, e_wdata);
                end
            end
            checks++;
            if (busy !== (cyc > acc && cyc < free)) begin
                errors++; $display("FAIL rnd_busy c%0d: got %b want %b", cyc, busy, cyc > acc && cyc < free);
            end
            if (w >= 0) begin
                int lat;
                e_err   = (paddr[w] >= DEPTH);
                e_we    = pwe[w];
                e_id    = IW'(w);
                e_addr  = AW'(paddr[w]);
                e_wdata = DW'(pdata[w]);
                lat     = e_err ? 1 : (e_we ? 2 : 3);
                e_data  = (e_err || e_we) ? '0 : DW'(ref_mem[paddr[w]]);
                if (!e_err && e_we) ref_mem[paddr[w]] = pdata[w];
                acc   = cyc;
                rspc  = cyc + lat;
                free  = cyc + lat + 1;
                issue = e_err ? -1 : cyc + 1;
                last  = w;
                pend[w] = 0;
            end
        end
        clr_all();
        repeat (5) step();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        clr_all();
        test_reset();
        test_write();
        test_read();
        test_oob();
        test_round_robin();
        test_rerequest();
        test_reset_mid_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
